// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, clog2 helper and default line settings.
// Used by uart_rx, uart_baud_tick and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_DEFAULT_BAUDRATE = 9600;
  localparam int UART_DEFAULT_CLK_FREQ = 50000000;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every DIV clk cycles.
// The sync clear holds the phase at zero so the first tick lands DIV cycles after release.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  assign tick = !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop capture with valid/clear handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rxs
// START  | confirming start bit at its centre
// DATA   | shifting in NBIT data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, delivering or flagging the frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBIT       = 8,
  parameter int BAUDRATE   = UART_DEFAULT_BAUDRATE,
  parameter int CLK_FREQ   = UART_DEFAULT_CLK_FREQ,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = CLK_FREQ / (BAUDRATE * OVERSAMPLE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  input  logic            rx_clear,
  output logic [NBIT-1:0] rx_data,
  output logic            rx_valid,
  output logic            framing_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            overrun_err
);

  localparam int SW = clog2(OVERSAMPLE);
  localparam int BW = clog2(NBIT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBIT - 1);

  uart_state_e     state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NBIT-1:0] shreg_q, shreg_d;
  logic [NBIT-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            framing_err_q, framing_err_d;
  logic            overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif
  logic            rxs, tick, tick_clr, bit_smp;

  assign rxs      = sync2_q;
  assign tick_clr = (state_q == IDLE);
  assign bit_smp  = tick && (scnt_q == S_LAST);

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    sync1_d       = serial_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    scnt_d        = scnt_q;
    bcnt_d        = bcnt_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_clear;
    framing_err_d = 1'b0;
    overrun_err_d = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif
    if (tick && (state_q != IDLE)) scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (prev_q && !rxs) begin
          scnt_d  = '0;
          bcnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick && (scnt_q == S_MID)) begin
          if (!rxs) begin
            scnt_d  = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_smp) begin
          shreg_d = {rxs, shreg_q[NBIT-1:1]};
          if (bcnt_q == B_LAST) begin
            bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_smp) begin
          par_d   = rxs;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_smp) begin
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err_d = ^shreg_q ^ par_q;
`endif
          // A good stop overrides a same-cycle rx_clear, so the new byte stays valid.
          if (rxs) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_clear) overrun_err_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      scnt_q        <= '0;
      bcnt_q        <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      scnt_q        <= scnt_d;
      bcnt_q        <= bcnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a short tick divider; expected bytes go through a queue.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int NBIT       = 8;
  localparam int BAUDRATE   = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int CLK_FREQ   = BAUDRATE * OVERSAMPLE * 4;
  localparam int TICK_DIV   = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int BT         = TICK_DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
  localparam int NFB = NBIT + 2;
`else
  localparam int NFB = NBIT + 1;
`endif
  localparam int LAT = 3 + TICK_DIV * (OVERSAMPLE / 2 + OVERSAMPLE * NFB);

  logic            clk       = 1'b0;
  logic            reset     = 1'b0;
  logic            serial_in = 1'b1;
  logic            rx_clear  = 1'b0;
  logic [NBIT-1:0] rx_data;
  logic            rx_valid, framing_err, overrun_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
  logic            par_flip = 1'b0;
  int              pe_cnt = 0;
`endif

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  logic [NBIT-1:0] exp_q[$];

  uart_rx #(
    .NBIT(NBIT), .BAUDRATE(BAUDRATE), .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .rx_clear    (rx_clear),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framing_err === 1'b1) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt++;
`endif
  end

  function automatic logic [NBIT-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Caller is at a negedge; drives one full frame, leaves the line high.
  task automatic send_frame(input logic [NBIT-1:0] d, input logic stop_b, input bit push);
    if (push && stop_b) exp_q.push_back(d);
    serial_in = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < NBIT; i++) begin
      serial_in = d[i];
      repeat (BT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = ^d ^ par_flip;
    repeat (BT) @(negedge clk);
`endif
    serial_in = stop_b;
    repeat (BT) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < LAT + 20) begin
      @(posedge clk); #1;
      n++;
      if (rx_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (rx_data !== '0) begin fails++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (framing_err !== 1'b0) begin fails++; $display("FAIL reset_framing_err got %b want 0", framing_err); end
    tests++; if (overrun_err !== 1'b0) begin fails++; $display("FAIL reset_overrun_err got %b want 0", overrun_err); end
  endtask

  task automatic test_basic();
    int n;
    logic [NBIT-1:0] e;
    fe_cnt = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      wait_valid(n);
    join
    e = pop_exp();
    tests++; if (n < LAT - 1 || n > LAT + 1) begin fails++; $display("FAIL basic_latency got %0d want %0d+-1", n, LAT); end
    tests++; if (rx_data !== e) begin fails++; $display("FAIL basic_data got %h want %h", rx_data, e); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", rx_valid); end
    tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL basic_framing got %0d pulses want 0", fe_cnt); end
  endtask

  task automatic test_glitch();
    logic [NBIT-1:0] e;
    do_clear();
    fe_cnt = 0;
    serial_in = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idle(2 * BT);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
    tests++; if (fe_cnt !== 0 || overrun_err !== 1'b0) begin fails++; $display("FAIL glitch_err got fe=%0d ovr=%b want 0/0", fe_cnt, overrun_err); end
    send_frame(8'h5A, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (rx_data !== e || rx_valid !== 1'b1) begin fails++; $display("FAIL glitch_next got %h/%b want %h/1", rx_data, rx_valid, e); end
  endtask

  task automatic test_framing();
    logic [NBIT-1:0] e;
    do_clear();
    fe_cnt = 0;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(BT);
    tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL framing_pulse got %0d want 1", fe_cnt); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL framing_valid got %b want 0", rx_valid); end
    tests++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL framing_data_kept got %h want 5a", rx_data); end
    send_frame(8'h55, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (rx_data !== e || rx_valid !== 1'b1) begin fails++; $display("FAIL framing_recover got %h/%b want %h/1", rx_data, rx_valid, e); end
  endtask

  task automatic test_back_to_back();
    logic [NBIT-1:0] e;
    apply_reset();
    send_frame(8'h11, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (rx_data !== e || overrun_err !== 1'b0) begin fails++; $display("FAIL b2b_first got %h/%b want %h/0", rx_data, overrun_err, e); end
    send_frame(8'h22, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (rx_data !== e) begin fails++; $display("FAIL b2b_second_data got %h want %h", rx_data, e); end
    tests++; if (overrun_err !== 1'b1) begin fails++; $display("FAIL b2b_overrun got %b want 1", overrun_err); end
    apply_reset();
    tests++; if (overrun_err !== 1'b0) begin fails++; $display("FAIL b2b_overrun_reset got %b want 0", overrun_err); end
    send_frame(8'h11, 1'b1, 1'b1);
    e = pop_exp();
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
      end
    join
    e = pop_exp();
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_clear_valid got %b want 1", rx_valid); end
    tests++; if (overrun_err !== 1'b0) begin fails++; $display("FAIL b2b_clear_overrun got %b want 0", overrun_err); end
    tests++; if (rx_data !== e) begin fails++; $display("FAIL b2b_clear_data got %h want %h", rx_data, e); end
  endtask

  task automatic test_reset_mid_frame();
    logic [NBIT-1:0] e;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (3 * BT + BT / 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (rx_valid !== 1'b0 || rx_data !== '0) begin fails++; $display("FAIL midreset_clear got %h/%b want 00/0", rx_data, rx_valid); end
        reset = 1'b1;
      end
    join
    idle(BT);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL midreset_discard got %b want 0", rx_valid); end
    send_frame(8'h0F, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (rx_data !== e || rx_valid !== 1'b1) begin fails++; $display("FAIL midreset_next got %h/%b want %h/1", rx_data, rx_valid, e); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [NBIT-1:0] e;
    do_clear();
    pe_cnt = 0;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (pe_cnt !== 1) begin fails++; $display("FAIL parity_bad_pulse got %0d want 1", pe_cnt); end
    tests++; if (rx_valid !== 1'b1 || rx_data !== e) begin fails++; $display("FAIL parity_bad_deliver got %h/%b want %h/1", rx_data, rx_valid, e); end
    do_clear();
    pe_cnt = 0;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    e = pop_exp();
    tests++; if (pe_cnt !== 0) begin fails++; $display("FAIL parity_good_pulse got %0d want 0", pe_cnt); end
    tests++; if (rx_valid !== 1'b1 || rx_data !== e) begin fails++; $display("FAIL parity_good_deliver got %h/%b want %h/1", rx_data, rx_valid, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
